// File: rtl/ex_muldiv.sv
// EX-stage radix-2 sequential multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; signs are fixed up in a final cycle.
module ex_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [1:0]      r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_raw_a;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_acc;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic            r_busy;
  logic            r_done;

  // Operand magnitudes: op[0]==0 selects the signed variants.
  logic            w_signed;
  logic            w_sa;
  logic            w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  assign w_signed = ~op[0];
  assign w_sa     = w_signed & rs_val[WIDTH-1];
  assign w_sb     = w_signed & rt_val[WIDTH-1];
  assign w_mag_a  = w_sa ? (~rs_val + WIDTH'(1)) : rs_val;
  assign w_mag_b  = w_sb ? (~rt_val + WIDTH'(1)) : rt_val;

  // Multiply step: conditionally add multiplicand to the upper half, then shift right.
  logic [WIDTH:0]  w_mul_sum;
  logic [AW-1:0]   w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[AW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: shift in next dividend bit, keep the difference when it does not borrow.
  logic [WIDTH:0]  w_trial;
  logic [WIDTH:0]  w_diff;
  logic [AW-1:0]   w_div_next;

  assign w_trial    = r_acc[AW-1:WIDTH-1];
  assign w_diff     = w_trial - {1'b0, r_b};
  assign w_div_next = w_diff[WIDTH] ? {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Final sign fix-up and special cases.
  logic [AW-1:0]   w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic            w_div0;

  assign w_prod = r_neg_q ? (~r_acc + AW'(1)) : r_acc;
  assign w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[AW-1:WIDTH] + WIDTH'(1)) : r_acc[AW-1:WIDTH];
  assign w_div0 = r_op[1] & (r_b == '0);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_RUN;
      ST_RUN:  if (r_cnt == '0) w_next_state = ST_FIX;
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_raw_a <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mthi) r_hi <= rs_val;
          if (mtlo) r_lo <= rs_val;
          if (start) begin
            r_op    <= op;
            r_a     <= w_mag_a;
            r_b     <= w_mag_b;
            r_raw_a <= rs_val;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_cnt   <= CW'(WIDTH - 1);
            r_acc   <= op[1] ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
          end
        end
        ST_RUN: begin
          r_acc <= r_op[1] ? w_div_next : w_mul_next;
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        ST_FIX: begin
          r_done <= 1'b1;
          if (!r_op[1]) begin
            r_hi <= w_prod[AW-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (w_div0) begin
            r_hi <= r_raw_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: results, latency, busy width, ignored inputs, async reset.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_vec;
  int n_err;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic mh, input logic ml);
    @(negedge clk);
    op     = o;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    mthi   = mh;
    mtlo   = ml;
  endtask

  // Walks from the start edge (index 0) to done; optionally disturbs inputs mid-run.
  task automatic finish_op(input string tag, input logic [31:0] eh, input logic [31:0] el,
                           input bit inject, input bit mt_chk, input logic [31:0] mt_val);
    int ed;
    int nb;
    ed = -1;
    nb = 0;
    for (int i = 0; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        if (mt_chk) begin
          chk({tag, "_mt_hi"}, 64'(hi), 64'(mt_val));
          chk({tag, "_mt_lo"}, 64'(lo), 64'(mt_val));
        end
      end
      if (inject && i == 5) begin
        start  = 1'b1;
        mthi   = 1'b1;
        mtlo   = 1'b1;
        op     = OP_MULTU;
        rs_val = 32'h0000_AAAA;
        rt_val = 32'h0000_0003;
      end
      if (inject && i == 6) begin
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
      end
      if (busy) nb++;
      if (done) begin
        ed = i;
        break;
      end
    end
    chk({tag, "_lat"},  64'(ed), 64'd33);
    chk({tag, "_busy"}, 64'(nb), 64'd33);
    chk({tag, "_hi"},   64'(hi), 64'(eh));
    chk({tag, "_lo"},   64'(lo), 64'(el));
    @(posedge clk);
    #1;
    chk({tag, "_done_off"}, 64'(done), 64'd0);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    rs_val = '0;
    rt_val = '0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    finish_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 32'h0);

    launch(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0);
    finish_op("mult_neg3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0, 32'h0);

    launch(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    finish_op("mult_minsq", 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0);

    launch(OP_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    finish_op("mult_maxxm1", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0, 32'h0);

    launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    finish_op("div_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0);

    launch(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
    finish_op("div_7dm2", 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0);

    launch(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    finish_op("divu_100d7", 32'd2, 32'd14, 1'b0, 1'b0, 32'h0);

    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    finish_op("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0);

    launch(OP_DIVU, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
    finish_op("divu_by0", 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);

    launch(OP_DIV, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0);
    finish_op("div_neg_by0", 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);

    launch(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    finish_op("busy_ignore", 32'd2, 32'd14, 1'b1, 1'b0, 32'h0);

    // mthi alone in IDLE: hi updates next edge, lo keeps the previous quotient.
    @(negedge clk);
    rs_val = 32'h0000_0055;
    mthi   = 1'b1;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    chk("mthi_hi",   64'(hi),   64'h55);
    chk("mthi_lo",   64'(lo),   64'd14);
    chk("mthi_busy", 64'(busy), 64'd0);

    launch(OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b1);
    finish_op("mt_with_start", 32'd2, 32'd14, 1'b0, 1'b1, 32'd100);

    // Asynchronous reset in the middle of a run.
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi",   64'(hi),   64'd0);
    chk("arst_lo",   64'(lo),   64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    launch(OP_MULTU, 32'd6, 32'd7, 1'b0, 1'b0);
    finish_op("multu_6x7", 32'd0, 32'd42, 1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
